nasti_mux: RTL and testbench

- Eight-to-one NASTI (AXI4 / AXI4-Lite) multiplexer; the converging counterpart of the address-decoding demultiplexer.
- Up to eight upstream masters share one downstream slave.
- AW and AR requests are granted by registered round-robin arbiters. Write data is locked to the AW winner until the burst ends.
- A 3-bit port index is prepended to the downstream ID. B and R responses are steered back upstream by those ID bits.

---
 rtl/nasti_mux_if.sv | 110 +++++++++++
 rtl/nasti_mux.sv | 240 ++++++++++++++++++++++++
 tb/tb_nasti_mux.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nasti_mux_if.sv
// nasti_channel: bundle of the five NASTI (AXI4 / AXI4-Lite) channels,
// replicated over N_LANES lanes.
//
// Each signal is a packed array indexed by lane, so the same interface type
// serves two purposes. An eight-lane instance carries the upstream ports of
// a multiplexer. A one-lane instance carries a single downstream port.
//
// Modports:
//   master - drives AW/W/AR and the B/R readies; receives everything else.
//   slave  - the mirror image of master.
//
// Parameters:
//   N_LANES    number of parallel ports carried by this bundle
//   ID_WIDTH   transaction ID width
//   ADDR_WIDTH address width
//   DATA_WIDTH data width (multiple of 8; strobe is DATA_WIDTH/8)
//   USER_WIDTH user sideband width (> 0)
interface nasti_channel #(
  parameter int N_LANES    = 1,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // write address channel
  logic [N_LANES-1:0][ID_WIDTH-1:0]   aw_id;
  logic [N_LANES-1:0][ADDR_WIDTH-1:0] aw_addr;
  logic [N_LANES-1:0][7:0]            aw_len;
  logic [N_LANES-1:0][2:0]            aw_size;
  logic [N_LANES-1:0][1:0]            aw_burst;
  logic [N_LANES-1:0]                 aw_lock;
  logic [N_LANES-1:0][3:0]            aw_cache;
  logic [N_LANES-1:0][2:0]            aw_prot;
  logic [N_LANES-1:0][3:0]            aw_qos;
  logic [N_LANES-1:0][3:0]            aw_region;
  logic [N_LANES-1:0][USER_WIDTH-1:0] aw_user;
  logic [N_LANES-1:0]                 aw_valid;
  logic [N_LANES-1:0]                 aw_ready;

  // write data channel
  logic [N_LANES-1:0][DATA_WIDTH-1:0] w_data;
  logic [N_LANES-1:0][STRB_WIDTH-1:0] w_strb;
  logic [N_LANES-1:0]                 w_last;
  logic [N_LANES-1:0][USER_WIDTH-1:0] w_user;
  logic [N_LANES-1:0]                 w_valid;
  logic [N_LANES-1:0]                 w_ready;

  // write response channel
  logic [N_LANES-1:0][ID_WIDTH-1:0]   b_id;
  logic [N_LANES-1:0][1:0]            b_resp;
  logic [N_LANES-1:0][USER_WIDTH-1:0] b_user;
  logic [N_LANES-1:0]                 b_valid;
  logic [N_LANES-1:0]                 b_ready;

  // read address channel
  logic [N_LANES-1:0][ID_WIDTH-1:0]   ar_id;
  logic [N_LANES-1:0][ADDR_WIDTH-1:0] ar_addr;
  logic [N_LANES-1:0][7:0]            ar_len;
  logic [N_LANES-1:0][2:0]            ar_size;
  logic [N_LANES-1:0][1:0]            ar_burst;
  logic [N_LANES-1:0]                 ar_lock;
  logic [N_LANES-1:0][3:0]            ar_cache;
  logic [N_LANES-1:0][2:0]            ar_prot;
  logic [N_LANES-1:0][3:0]            ar_qos;
  logic [N_LANES-1:0][3:0]            ar_region;
  logic [N_LANES-1:0][USER_WIDTH-1:0] ar_user;
  logic [N_LANES-1:0]                 ar_valid;
  logic [N_LANES-1:0]                 ar_ready;

  // read data channel
  logic [N_LANES-1:0][ID_WIDTH-1:0]   r_id;
  logic [N_LANES-1:0][DATA_WIDTH-1:0] r_data;
  logic [N_LANES-1:0][1:0]            r_resp;
  logic [N_LANES-1:0]                 r_last;
  logic [N_LANES-1:0][USER_WIDTH-1:0] r_user;
  logic [N_LANES-1:0]                 r_valid;
  logic [N_LANES-1:0]                 r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_mux.sv
// nasti_mux: eight-to-one NASTI (AXI4 / AXI4-Lite) multiplexer.
//
// Up to eight upstream masters share one downstream slave. The AW and AR
// channels each have their own registered arbiter. The write data channel
// stays locked to the AW winner until that burst's last beat. The winning
// port index (3 bits) is prepended to the downstream ID. B and R responses
// are steered back upstream using those top three ID bits. The response
// steering is purely combinational.
//
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset
//   s     - nasti_channel.slave, 8 lanes, ID_WIDTH-bit IDs (upstream)
//   m     - nasti_channel.master, 1 lane, (ID_WIDTH+3)-bit IDs (downstream)
//
// Parameters:
//   ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH - channel field widths
//   LITE_MODE - 1: every W beat ends the burst (w_last ignored)
//
// Configuration macro:
//   NASTI_MUX_FIXED_PRIO_EN - when defined, both arbiters use fixed priority
//   (the lowest requesting index wins) and the round-robin pointers are
//   removed. When undefined, the arbiters are round-robin.
module nasti_mux #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int LITE_MODE  = 0
) (
  input  logic         clk,
  input  logic         rstn,
  nasti_channel.slave  s,
  nasti_channel.master m
);

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    AW_GRANT = 2'd1,
    W_BURST  = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE   = 1'b0,
    AR_GRANT = 1'b1
  } r_state_e;

  w_state_e   w_state_q, w_state_d;
  r_state_e   r_state_q, r_state_d;
  logic [2:0] wsel_q, wsel_d;
  logic [2:0] rsel_q, rsel_d;
  logic [2:0] aw_pick, ar_pick;
  logic [2:0] b_port, r_port;

  // Returns the first requester at or after ptr, scanning upward and
  // wrapping from 7 to 0. Callers only use the result when req is non-zero.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef NASTI_MUX_FIXED_PRIO_EN
  // Fixed priority: a scan that always starts at index 0.
  assign aw_pick = rr_pick(s.aw_valid, 3'd0);
  assign ar_pick = rr_pick(s.ar_valid, 3'd0);
`else
  logic [2:0] wptr_q, wptr_d;
  logic [2:0] rptr_q, rptr_d;

  assign aw_pick = rr_pick(s.aw_valid, wptr_q);
  assign ar_pick = rr_pick(s.ar_valid, rptr_q);

  // Each pointer moves one past the port that was just served. The write
  // pointer moves when the burst completes, not when AW is accepted.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (w_state_q == W_BURST && s.w_valid[wsel_q] && m.w_ready[0] &&
        ((LITE_MODE != 0) || s.w_last[wsel_q])) begin
      wptr_d = wsel_q + 3'd1;
    end
    if (r_state_q == AR_GRANT && s.ar_valid[rsel_q] && m.ar_ready[0]) begin
      rptr_d = rsel_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= 3'd0;
      rptr_q <= 3'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      wsel_q    <= 3'd0;
      rsel_q    <= 3'd0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
    end
  end

  // Write path. The payload fields always follow wsel_q. Only the valids and
  // readies are gated by state. The grant is held until the handshake, so
  // downstream AW and W stay stable while their valids are pending.
  always_comb begin
    w_state_d = w_state_q;
    wsel_d    = wsel_q;

    m.aw_id[0]     = {wsel_q, s.aw_id[wsel_q][ID_WIDTH-1:0]};
    m.aw_addr[0]   = s.aw_addr[wsel_q][ADDR_WIDTH-1:0];
    m.aw_len[0]    = s.aw_len[wsel_q];
    m.aw_size[0]   = s.aw_size[wsel_q];
    m.aw_burst[0]  = s.aw_burst[wsel_q];
    m.aw_lock[0]   = s.aw_lock[wsel_q];
    m.aw_cache[0]  = s.aw_cache[wsel_q];
    m.aw_prot[0]   = s.aw_prot[wsel_q];
    m.aw_qos[0]    = s.aw_qos[wsel_q];
    m.aw_region[0] = s.aw_region[wsel_q];
    m.aw_user[0]   = s.aw_user[wsel_q][USER_WIDTH-1:0];
    m.aw_valid[0]  = 1'b0;
    s.aw_ready     = '0;

    m.w_data[0]    = s.w_data[wsel_q][DATA_WIDTH-1:0];
    m.w_strb[0]    = s.w_strb[wsel_q];
    m.w_last[0]    = s.w_last[wsel_q];
    m.w_user[0]    = s.w_user[wsel_q][USER_WIDTH-1:0];
    m.w_valid[0]   = 1'b0;
    s.w_ready      = '0;

    unique case (w_state_q)
      W_IDLE: begin
        if (|s.aw_valid) begin
          wsel_d    = aw_pick;
          w_state_d = AW_GRANT;
        end
      end
      AW_GRANT: begin
        m.aw_valid[0]      = s.aw_valid[wsel_q];
        s.aw_ready[wsel_q] = m.aw_ready[0];
        if (s.aw_valid[wsel_q] && m.aw_ready[0]) begin
          w_state_d = W_BURST;
        end
      end
      W_BURST: begin
        m.w_valid[0]      = s.w_valid[wsel_q];
        s.w_ready[wsel_q] = m.w_ready[0];
        if (s.w_valid[wsel_q] && m.w_ready[0] &&
            ((LITE_MODE != 0) || s.w_last[wsel_q])) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read address path: the same pattern as AW, but without a data lock.
  always_comb begin
    r_state_d = r_state_q;
    rsel_d    = rsel_q;

    m.ar_id[0]     = {rsel_q, s.ar_id[rsel_q][ID_WIDTH-1:0]};
    m.ar_addr[0]   = s.ar_addr[rsel_q][ADDR_WIDTH-1:0];
    m.ar_len[0]    = s.ar_len[rsel_q];
    m.ar_size[0]   = s.ar_size[rsel_q];
    m.ar_burst[0]  = s.ar_burst[rsel_q];
    m.ar_lock[0]   = s.ar_lock[rsel_q];
    m.ar_cache[0]  = s.ar_cache[rsel_q];
    m.ar_prot[0]   = s.ar_prot[rsel_q];
    m.ar_qos[0]    = s.ar_qos[rsel_q];
    m.ar_region[0] = s.ar_region[rsel_q];
    m.ar_user[0]   = s.ar_user[rsel_q][USER_WIDTH-1:0];
    m.ar_valid[0]  = 1'b0;
    s.ar_ready     = '0;

    unique case (r_state_q)
      R_IDLE: begin
        if (|s.ar_valid) begin
          rsel_d    = ar_pick;
          r_state_d = AR_GRANT;
        end
      end
      AR_GRANT: begin
        m.ar_valid[0]      = s.ar_valid[rsel_q];
        s.ar_ready[rsel_q] = m.ar_ready[0];
        if (s.ar_valid[rsel_q] && m.ar_ready[0]) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Response steering. The top three ID bits select the upstream lane. The
  // payload is broadcast to every lane, but only the selected lane sees
  // valid, and only that lane's ready reaches downstream.
  assign b_port = m.b_id[0][ID_WIDTH+2:ID_WIDTH];
  assign r_port = m.r_id[0][ID_WIDTH+2:ID_WIDTH];

  always_comb begin
    s.b_valid         = '0;
    s.b_valid[b_port] = m.b_valid[0];
    m.b_ready[0]      = s.b_ready[b_port];
    s.r_valid         = '0;
    s.r_valid[r_port] = m.r_valid[0];
    m.r_ready[0]      = s.r_ready[r_port];
    for (int i = 0; i < 8; i++) begin
      s.b_id[i]   = m.b_id[0][ID_WIDTH-1:0];
      s.b_resp[i] = m.b_resp[0];
      s.b_user[i] = m.b_user[0][USER_WIDTH-1:0];
      s.r_id[i]   = m.r_id[0][ID_WIDTH-1:0];
      s.r_data[i] = m.r_data[0][DATA_WIDTH-1:0];
      s.r_resp[i] = m.r_resp[0];
      s.r_last[i] = m.r_last[0];
      s.r_user[i] = m.r_user[0][USER_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_nasti_mux.sv
// Testbench for nasti_mux.
//
// Inputs are driven on the falling clock edge and outputs are sampled 1 ns
// later. The routing table covers the combinational B/R steering. The
// hand-written sequences cover arbitration, W locking, reset and lite mode.
`timescale 1ns/1ps
module tb_nasti_mux;
  localparam int IDW = 1;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int UW  = 1;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nasti_channel #(.N_LANES(8), .ID_WIDTH(IDW), .ADDR_WIDTH(AW),
                  .DATA_WIDTH(DW), .USER_WIDTH(UW)) up_if ();
  nasti_channel #(.N_LANES(1), .ID_WIDTH(IDW+3), .ADDR_WIDTH(AW),
                  .DATA_WIDTH(DW), .USER_WIDTH(UW)) dn_if ();
  nasti_channel #(.N_LANES(8), .ID_WIDTH(IDW), .ADDR_WIDTH(AW),
                  .DATA_WIDTH(DW), .USER_WIDTH(UW)) up_lite ();
  nasti_channel #(.N_LANES(1), .ID_WIDTH(IDW+3), .ADDR_WIDTH(AW),
                  .DATA_WIDTH(DW), .USER_WIDTH(UW)) dn_lite ();

  nasti_mux #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
              .USER_WIDTH(UW), .LITE_MODE(0)) dut (
    .clk(clk), .rstn(rstn), .s(up_if), .m(dn_if));

  nasti_mux #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
              .USER_WIDTH(UW), .LITE_MODE(1)) dut_lite (
    .clk(clk), .rstn(rstn), .s(up_lite), .m(dn_lite));

  typedef struct {
    logic       is_read;
    logic [2:0] port;
    logic       id;
    logic       valid;
    logic [7:0] up_ready;
    logic [7:0] payload;
    logic [7:0] exp_valid;
    logic       exp_ready;
  } route_vec_t;

  route_vec_t vecs [7];
  logic [2:0] exp_ar [6];
  logic       ar_id_bit [8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    up_if.aw_id = '0; up_if.aw_addr = '0; up_if.aw_len = '0; up_if.aw_size = '0;
    up_if.aw_burst = '0; up_if.aw_lock = '0; up_if.aw_cache = '0; up_if.aw_prot = '0;
    up_if.aw_qos = '0; up_if.aw_region = '0; up_if.aw_user = '0; up_if.aw_valid = '0;
    up_if.ar_id = '0; up_if.ar_addr = '0; up_if.ar_len = '0; up_if.ar_size = '0;
    up_if.ar_burst = '0; up_if.ar_lock = '0; up_if.ar_cache = '0; up_if.ar_prot = '0;
    up_if.ar_qos = '0; up_if.ar_region = '0; up_if.ar_user = '0; up_if.ar_valid = '0;
    up_if.w_data = '0; up_if.w_strb = '1; up_if.w_last = '0; up_if.w_user = '0;
    up_if.w_valid = '0; up_if.b_ready = '0; up_if.r_ready = '0;
    dn_if.aw_ready = '0; dn_if.w_ready = '0; dn_if.ar_ready = '0;
    dn_if.b_id = '0; dn_if.b_resp = '0; dn_if.b_user = '0; dn_if.b_valid = '0;
    dn_if.r_id = '0; dn_if.r_data = '0; dn_if.r_resp = '0; dn_if.r_last = '0;
    dn_if.r_user = '0; dn_if.r_valid = '0;
    up_lite.aw_id = '0; up_lite.aw_addr = '0; up_lite.aw_len = '0; up_lite.aw_size = '0;
    up_lite.aw_burst = '0; up_lite.aw_lock = '0; up_lite.aw_cache = '0; up_lite.aw_prot = '0;
    up_lite.aw_qos = '0; up_lite.aw_region = '0; up_lite.aw_user = '0; up_lite.aw_valid = '0;
    up_lite.ar_id = '0; up_lite.ar_addr = '0; up_lite.ar_len = '0; up_lite.ar_size = '0;
    up_lite.ar_burst = '0; up_lite.ar_lock = '0; up_lite.ar_cache = '0; up_lite.ar_prot = '0;
    up_lite.ar_qos = '0; up_lite.ar_region = '0; up_lite.ar_user = '0; up_lite.ar_valid = '0;
    up_lite.w_data = '0; up_lite.w_strb = '1; up_lite.w_last = '0; up_lite.w_user = '0;
    up_lite.w_valid = '0; up_lite.b_ready = '0; up_lite.r_ready = '0;
    dn_lite.aw_ready = '0; dn_lite.w_ready = '0; dn_lite.ar_ready = '0;
    dn_lite.b_id = '0; dn_lite.b_resp = '0; dn_lite.b_user = '0; dn_lite.b_valid = '0;
    dn_lite.r_id = '0; dn_lite.r_data = '0; dn_lite.r_resp = '0; dn_lite.r_last = '0;
    dn_lite.r_user = '0; dn_lite.r_valid = '0;
  endtask

  // Presents one downstream response with the given upstream readies.
  task automatic applyStimulus(input route_vec_t v);
    dn_if.b_valid  = '0;
    dn_if.r_valid  = '0;
    up_if.b_ready  = '0;
    up_if.r_ready  = '0;
    if (v.is_read) begin
      dn_if.r_id[0]   = {v.port, v.id};
      dn_if.r_data[0] = v.payload;
      dn_if.r_last[0] = 1'b1;
      dn_if.r_valid   = v.valid;
      up_if.r_ready   = v.up_ready;
    end else begin
      dn_if.b_id[0]   = {v.port, v.id};
      dn_if.b_resp[0] = v.payload[1:0];
      dn_if.b_valid   = v.valid;
      up_if.b_ready   = v.up_ready;
    end
  endtask

  // Overall time limit, so the run cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int g;
    int last_cyc;

    //          rd    port  id    valid up_rdy pay    exp_v  exp_rdy
    vecs[0] = '{1'b0, 3'd5, 1'b1, 1'b1, 8'h20, 8'h02, 8'h20, 1'b1};
    vecs[1] = '{1'b0, 3'd0, 1'b0, 1'b1, 8'hFE, 8'h01, 8'h01, 1'b0};
    vecs[2] = '{1'b0, 3'd7, 1'b0, 1'b0, 8'h80, 8'h03, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 3'd6, 1'b1, 1'b1, 8'hBF, 8'hA5, 8'h40, 1'b0};
    vecs[4] = '{1'b1, 3'd6, 1'b1, 1'b1, 8'h40, 8'h5A, 8'h40, 1'b1};
    vecs[5] = '{1'b1, 3'd3, 1'b0, 1'b1, 8'h08, 8'hC3, 8'h08, 1'b1};
    vecs[6] = '{1'b1, 3'd2, 1'b1, 1'b1, 8'h00, 8'h7E, 8'h04, 1'b0};
`ifdef NASTI_MUX_FIXED_PRIO_EN
    exp_ar = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
    exp_ar = '{3'd0, 3'd1, 3'd7, 3'd0, 3'd1, 3'd7};
`endif
    ar_id_bit = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // ---------------- reset state
    rstn = 1'b1;
    clearInputs();
    #2 rstn = 1'b0;
    #2;
    checkOutput("rst_m_aw_valid", 32'(dn_if.aw_valid), 0);
    checkOutput("rst_m_w_valid", 32'(dn_if.w_valid), 0);
    checkOutput("rst_m_ar_valid", 32'(dn_if.ar_valid), 0);
    checkOutput("rst_s_aw_ready", 32'(up_if.aw_ready), 0);
    checkOutput("rst_s_w_ready", 32'(up_if.w_ready), 0);
    checkOutput("rst_s_ar_ready", 32'(up_if.ar_ready), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // ---------------- B/R routing table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      if (vecs[i].is_read) begin
        checkOutput($sformatf("r_valid_v%0d", i), 32'(up_if.r_valid), 32'(vecs[i].exp_valid));
        checkOutput($sformatf("r_ready_v%0d", i), 32'(dn_if.r_ready), 32'(vecs[i].exp_ready));
        checkOutput($sformatf("r_id_v%0d", i), 32'(up_if.r_id[0]), 32'(vecs[i].id));
        checkOutput($sformatf("r_data_v%0d", i), 32'(up_if.r_data[7]), 32'(vecs[i].payload));
      end else begin
        checkOutput($sformatf("b_valid_v%0d", i), 32'(up_if.b_valid), 32'(vecs[i].exp_valid));
        checkOutput($sformatf("b_ready_v%0d", i), 32'(dn_if.b_ready), 32'(vecs[i].exp_ready));
        checkOutput($sformatf("b_id_v%0d", i), 32'(up_if.b_id[0]), 32'(vecs[i].id));
        checkOutput($sformatf("b_resp_v%0d", i), 32'(up_if.b_resp[7]), 32'(vecs[i].payload[1:0]));
      end
    end
    @(negedge clk);
    dn_if.b_valid = '0;
    dn_if.r_valid = '0;

    // ---------------- ports 2 and 5 request AW together; port 2 len 3
    @(negedge clk);
    up_if.aw_id[2] = 1'b1; up_if.aw_addr[2] = 8'h22; up_if.aw_len[2] = 8'd3;
    up_if.aw_id[5] = 1'b0; up_if.aw_addr[5] = 8'h55; up_if.aw_len[5] = 8'd0;
    up_if.aw_valid = 8'h24;
    dn_if.aw_ready = 1'b1;
    dn_if.w_ready  = 1'b1;
    #1;
    checkOutput("aw_idle_valid", 32'(dn_if.aw_valid), 0);
    checkOutput("aw_idle_ready", 32'(up_if.aw_ready), 0);
    @(negedge clk); #1;
    checkOutput("aw2_valid", 32'(dn_if.aw_valid), 1);
    checkOutput("aw2_id", 32'(dn_if.aw_id[0]), 32'h5);
    checkOutput("aw2_addr", 32'(dn_if.aw_addr[0]), 32'h22);
    checkOutput("aw2_len", 32'(dn_if.aw_len[0]), 3);
    checkOutput("aw2_s_ready", 32'(up_if.aw_ready), 32'h04);
    for (int beat = 0; beat < 4; beat++) begin
      @(negedge clk);
      up_if.aw_valid[2] = 1'b0;
      up_if.w_valid[2]  = 1'b1;
      up_if.w_data[2]   = 8'(8'hD0 + beat);
      up_if.w_last[2]   = (beat == 3);
      up_if.w_valid[5]  = 1'b1;
      up_if.w_data[5]   = 8'h5F;
      up_if.w_last[5]   = 1'b1;
      #1;
      checkOutput($sformatf("w2_valid_b%0d", beat), 32'(dn_if.w_valid), 1);
      checkOutput($sformatf("w2_data_b%0d", beat), 32'(dn_if.w_data[0]), 32'(8'hD0) + 32'(beat));
      checkOutput($sformatf("w2_last_b%0d", beat), 32'(dn_if.w_last[0]), (beat == 3) ? 1 : 0);
      checkOutput($sformatf("w2_s_ready_b%0d", beat), 32'(up_if.w_ready), 32'h04);
      checkOutput($sformatf("w2_aw_valid_b%0d", beat), 32'(dn_if.aw_valid), 0);
    end
    @(negedge clk);
    up_if.w_valid[2] = 1'b0;
    up_if.w_last[2]  = 1'b0;
    #1;
    checkOutput("w_idle_after_burst_aw", 32'(dn_if.aw_valid), 0);
    checkOutput("w_idle_after_burst_wr", 32'(up_if.w_ready), 0);
    @(negedge clk); #1;
    checkOutput("aw5_valid", 32'(dn_if.aw_valid), 1);
    checkOutput("aw5_id", 32'(dn_if.aw_id[0]), 32'hA);
    checkOutput("aw5_addr", 32'(dn_if.aw_addr[0]), 32'h55);
    checkOutput("aw5_s_ready", 32'(up_if.aw_ready), 32'h20);
    checkOutput("w5_stalled", 32'(up_if.w_ready), 0);
    @(negedge clk);
    up_if.aw_valid[5] = 1'b0;
    #1;
    checkOutput("w5_s_ready", 32'(up_if.w_ready), 32'h20);
    checkOutput("w5_data", 32'(dn_if.w_data[0]), 32'h5F);
    checkOutput("w5_last", 32'(dn_if.w_last[0]), 1);
    @(negedge clk);
    up_if.w_valid[5] = 1'b0;
    up_if.w_last[5]  = 1'b0;
    #1;
    checkOutput("w5_done", 32'(up_if.w_ready), 0);

    // ---------------- port 3 presents W two cycles before its AW
    @(negedge clk);
    up_if.w_valid[3] = 1'b1; up_if.w_data[3] = 8'h3C; up_if.w_last[3] = 1'b1;
    #1;
    checkOutput("w3_early_ready0", 32'(up_if.w_ready), 0);
    checkOutput("w3_early_fwd0", 32'(dn_if.w_valid), 0);
    @(negedge clk); #1;
    checkOutput("w3_early_ready1", 32'(up_if.w_ready), 0);
    @(negedge clk);
    up_if.aw_id[3] = 1'b0; up_if.aw_addr[3] = 8'h33; up_if.aw_len[3] = 8'd0;
    up_if.aw_valid[3] = 1'b1;
    #1;
    checkOutput("w3_early_ready2", 32'(up_if.w_ready), 0);
    @(negedge clk); #1;
    checkOutput("aw3_valid", 32'(dn_if.aw_valid), 1);
    checkOutput("aw3_id", 32'(dn_if.aw_id[0]), 32'h6);
    checkOutput("w3_grant_fwd", 32'(dn_if.w_valid), 0);
    checkOutput("w3_grant_ready", 32'(up_if.w_ready), 0);
    @(negedge clk);
    up_if.aw_valid[3] = 1'b0;
    #1;
    checkOutput("w3_burst_ready", 32'(up_if.w_ready), 32'h08);
    checkOutput("w3_burst_valid", 32'(dn_if.w_valid), 1);
    checkOutput("w3_burst_data", 32'(dn_if.w_data[0]), 32'h3C);
    @(negedge clk);
    up_if.w_valid[3] = 1'b0;
    up_if.w_last[3]  = 1'b0;
    #1;
    checkOutput("w3_done", 32'(up_if.w_ready), 0);

    // ---------------- ports 0, 1 and 7 hold ar_valid for six grants
    @(negedge clk);
    up_if.ar_id[0] = 1'b1; up_if.ar_id[1] = 1'b0; up_if.ar_id[7] = 1'b1;
    up_if.ar_valid = 8'h83;
    dn_if.ar_ready = 1'b1;
    g = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && g < 6; cyc++) begin
      @(negedge clk); #1;
      if (dn_if.ar_valid[0]) begin
        checkOutput($sformatf("ar_port_g%0d", g), 32'(dn_if.ar_id[0][3:1]), 32'(exp_ar[g]));
        checkOutput($sformatf("ar_idbit_g%0d", g), 32'(dn_if.ar_id[0][0]), 32'(ar_id_bit[exp_ar[g]]));
        checkOutput($sformatf("ar_s_ready_g%0d", g), 32'(up_if.ar_ready), 32'(8'h01 << exp_ar[g]));
        if (g > 0) checkOutput($sformatf("ar_spacing_g%0d", g), 32'(cyc - last_cyc), 2);
        last_cyc = cyc;
        g++;
      end
    end
    if (g < 6) checkOutput("ar_grant_timeout", 32'(g), 6);
    @(negedge clk);
    up_if.ar_valid = '0;
    dn_if.ar_ready = 1'b0;

    // ---------------- reset during the 2nd of 4 W beats (port 1)
    @(negedge clk);
    up_if.aw_id[1] = 1'b1; up_if.aw_len[1] = 8'd3; up_if.aw_valid[1] = 1'b1;
    @(negedge clk); #1;
    checkOutput("aw1_valid", 32'(dn_if.aw_valid), 1);
    checkOutput("aw1_port", 32'(dn_if.aw_id[0][3:1]), 1);
    @(negedge clk);
    up_if.aw_valid[1] = 1'b0;
    up_if.w_valid[1]  = 1'b1; up_if.w_data[1] = 8'h10; up_if.w_last[1] = 1'b0;
    #1;
    checkOutput("w1_beat0_ready", 32'(up_if.w_ready), 32'h02);
    @(negedge clk);
    up_if.w_data[1] = 8'h11;
    #1;
    checkOutput("w1_beat1_ready", 32'(up_if.w_ready), 32'h02);
    rstn = 1'b0;
    #1;
    checkOutput("rst_mid_w_valid", 32'(dn_if.w_valid), 0);
    checkOutput("rst_mid_w_ready", 32'(up_if.w_ready), 0);
    checkOutput("rst_mid_aw_valid", 32'(dn_if.aw_valid), 0);
    checkOutput("rst_mid_ar_valid", 32'(dn_if.ar_valid), 0);
    @(negedge clk);
    rstn = 1'b1;
    up_if.w_valid[1] = 1'b0;
    up_if.aw_id[6] = 1'b0;
    up_if.aw_valid = 8'h42;
    #1;
    checkOutput("post_rst_idle", 32'(dn_if.aw_valid), 0);
    @(negedge clk); #1;
    checkOutput("post_rst_valid", 32'(dn_if.aw_valid), 1);
    checkOutput("post_rst_ptr0_id", 32'(dn_if.aw_id[0]), 32'h3);
    @(negedge clk);
    up_if.aw_valid = '0;

    // ---------------- LITE_MODE: one beat releases the lock, w_last low
    @(negedge clk);
    up_lite.aw_id[4] = 1'b0; up_lite.aw_len[4] = 8'd3;
    up_lite.aw_id[6] = 1'b1;
    up_lite.aw_valid = 8'h50;
    dn_lite.aw_ready = 1'b1;
    dn_lite.w_ready  = 1'b1;
    #1;
    checkOutput("lite_idle", 32'(dn_lite.aw_valid), 0);
    @(negedge clk); #1;
    checkOutput("lite_aw4_valid", 32'(dn_lite.aw_valid), 1);
    checkOutput("lite_aw4_id", 32'(dn_lite.aw_id[0]), 32'h8);
    checkOutput("lite_aw4_ready", 32'(up_lite.aw_ready), 32'h10);
    @(negedge clk);
    up_lite.aw_valid[4] = 1'b0;
    up_lite.w_valid[4]  = 1'b1; up_lite.w_data[4] = 8'h44; up_lite.w_last[4] = 1'b0;
    #1;
    checkOutput("lite_w_ready", 32'(up_lite.w_ready), 32'h10);
    checkOutput("lite_w_valid", 32'(dn_lite.w_valid), 1);
    @(negedge clk); #1;
    checkOutput("lite_released_ready", 32'(up_lite.w_ready), 0);
    checkOutput("lite_released_valid", 32'(dn_lite.w_valid), 0);
    @(negedge clk); #1;
    checkOutput("lite_aw6_valid", 32'(dn_lite.aw_valid), 1);
    checkOutput("lite_aw6_id", 32'(dn_lite.aw_id[0]), 32'hD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
